gpio_pad_ctrl: RTL and testbench

Logic-side controller for a bank of bidirectional 8 mA pad cells with active-low output enable. It drives each pad's output data and NOE from registered push-pull or open-drain settings. It samples each pad's input through a two-flop synchronizer and a programmable glitch filter, and raises sticky edge-interrupt flags. It sits between the GPIO register block (HCLK domain) and the pad ring.

---
 rtl/gpio_pad_ctrl.sv | 104 ++++++++++
 tb/tb_gpio_pad_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_pad_ctrl.sv
// GPIO pad-ring controller: registered push-pull/open-drain output drive,
// synchronized and glitch-filtered input sampling, sticky edge interrupts.
module gpio_pad_ctrl #(
    parameter int WIDTH  = 8,
    parameter int FILT_W = 4
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic [WIDTH-1:0]  out_data,
    input  logic [WIDTH-1:0]  out_en,
    input  logic [WIDTH-1:0]  open_drain,
    input  logic [FILT_W-1:0] filt_cycles,
    input  logic [WIDTH-1:0]  irq_rise_en,
    input  logic [WIDTH-1:0]  irq_fall_en,
    input  logic [WIDTH-1:0]  irq_clr,
    input  logic [WIDTH-1:0]  pad_i,
    output logic [WIDTH-1:0]  pad_o,
    output logic [WIDTH-1:0]  pad_noe,
    output logic [WIDTH-1:0]  in_data,
    output logic [WIDTH-1:0]  rise_pend,
    output logic [WIDTH-1:0]  fall_pend,
    output logic              irq
);

    logic [WIDTH-1:0]  s1;
    logic [WIDTH-1:0]  s2;
    logic [FILT_W-1:0] cnt [WIDTH];

    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] upd;
    logic [WIDTH-1:0] noe_nxt;
    logic [WIDTH-1:0] o_nxt;
    logic [WIDTH-1:0] rise_set;
    logic [WIDTH-1:0] fall_set;

    // Open-drain bits only ever pull low; releasing is done via NOE.
    always_comb begin
        o_nxt   = out_data & ~open_drain;
        noe_nxt = (~open_drain & ~out_en)
                | ( open_drain & ~(out_en & ~out_data));
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            pad_o   <= '0;
            pad_noe <= '1;
        end else begin
            pad_o   <= o_nxt;
            pad_noe <= noe_nxt;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= pad_i;
            s2 <= s1;
        end
    end

    always_comb begin
        diff = s2 ^ in_data;
        upd  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            upd[i] = diff[i] && (cnt[i] >= filt_cycles);
        end
        rise_set = upd &  s2 & irq_rise_en;
        fall_set = upd & ~s2 & irq_fall_en;
    end

    // cnt stays below filt_cycles while counting, so it cannot wrap.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (upd[i] || !diff[i]) begin
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            in_data   <= '0;
            rise_pend <= '0;
            fall_pend <= '0;
        end else begin
            in_data   <= in_data ^ upd;
            rise_pend <= rise_set | (rise_pend & ~irq_clr);
            fall_pend <= fall_set | (fall_pend & ~irq_clr);
        end
    end

    assign irq = |{rise_pend, fall_pend};

endmodule

// File: tb/tb_gpio_pad_ctrl.sv
// Scoreboard bench for gpio_pad_ctrl: expectations queued at drive time,
// popped and compared when the DUT output is sampled.
module tb_gpio_pad_ctrl;

    logic       HCLK;
    logic       HRESETn;
    logic [7:0] out_data;
    logic [7:0] out_en;
    logic [7:0] open_drain;
    logic [3:0] filt_cycles;
    logic [7:0] irq_rise_en;
    logic [7:0] irq_fall_en;
    logic [7:0] irq_clr;
    logic [7:0] pad_i;
    logic [7:0] pad_o;
    logic [7:0] pad_noe;
    logic [7:0] in_data;
    logic [7:0] rise_pend;
    logic [7:0] fall_pend;
    logic       irq;

    gpio_pad_ctrl #(.WIDTH(8), .FILT_W(4)) dut (
        .HCLK        (HCLK),
        .HRESETn     (HRESETn),
        .out_data    (out_data),
        .out_en      (out_en),
        .open_drain  (open_drain),
        .filt_cycles (filt_cycles),
        .irq_rise_en (irq_rise_en),
        .irq_fall_en (irq_fall_en),
        .irq_clr     (irq_clr),
        .pad_i       (pad_i),
        .pad_o       (pad_o),
        .pad_noe     (pad_noe),
        .in_data     (in_data),
        .rise_pend   (rise_pend),
        .fall_pend   (fall_pend),
        .irq         (irq)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    typedef struct {
        string      tag;
        logic [7:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   errs  = 0;

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        n_chk++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input logic [7:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic pop(input logic [7:0] obs);
        exp_t e;
        if (sb.size() == 0) begin
            chk("sb_underflow", 8'(sb.size()), 8'd1);
        end else begin
            e = sb.pop_front();
            chk(e.tag, obs, e.val);
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    // Edge k is the first posedge after the pin change; update lands on 3+N.
    task automatic lat(input int b, input logic v, input logic [3:0] n,
                       input string t);
        logic [7:0] nw;
        @(negedge HCLK);
        filt_cycles = n;
        @(negedge HCLK);
        nw = pad_i;
        nw[b] = v;
        push({t, "_hold"}, pad_i);
        push({t, "_upd"}, nw);
        pad_i = nw;
        repeat (2 + int'(n)) tick();
        pop(in_data);
        tick();
        pop(in_data);
    endtask

    initial begin
        HRESETn     = 1'b0;
        out_en      = 8'hFF;
        out_data    = 8'hA5;
        open_drain  = 8'h00;
        filt_cycles = 4'd0;
        irq_rise_en = 8'h00;
        irq_fall_en = 8'h00;
        irq_clr     = 8'h00;
        pad_i       = 8'h00;

        repeat (3) tick();
        push("rst_noe", 8'hFF);
        push("rst_o", 8'h00);
        push("rst_irq", 8'h00);
        push("rst_in", 8'h00);
        pop(pad_noe);
        pop(pad_o);
        pop({7'b0, irq});
        pop(in_data);

        @(negedge HCLK);
        HRESETn = 1'b1;
        push("pp_o", 8'hA5);
        push("pp_noe", 8'h00);
        tick();
        pop(pad_o);
        pop(pad_noe);

        @(negedge HCLK);
        open_drain = 8'hFF;
        out_data   = 8'h0F;
        push("od_o", 8'h00);
        push("od_noe", 8'h0F);
        tick();
        pop(pad_o);
        pop(pad_noe);

        @(negedge HCLK);
        out_en = 8'h00;
        push("od_off_noe", 8'hFF);
        tick();
        pop(pad_noe);

        @(negedge HCLK);
        open_drain = 8'h0F;
        out_en     = 8'hFF;
        out_data   = 8'h33;
        push("mix_o", 8'h30);
        push("mix_noe", 8'h03);
        tick();
        pop(pad_o);
        pop(pad_noe);

        lat(0, 1'b1, 4'd0, "lat_n0");
        lat(0, 1'b0, 4'd5, "lat_n5");

        // Glitch rejection on pad 2 with N = 3.
        @(negedge HCLK);
        filt_cycles = 4'd3;
        irq_rise_en = 8'h04;
        @(negedge HCLK);
        pad_i = 8'h04;
        repeat (3) @(negedge HCLK);
        pad_i = 8'h00;
        repeat (10) tick();
        push("gl3_in", 8'h00);
        push("gl3_rise", 8'h00);
        pop(in_data);
        pop(rise_pend);

        @(negedge HCLK);
        pad_i = 8'h04;
        push("gl4_pre", 8'h00);
        push("gl4_in", 8'h04);
        push("gl4_rise", 8'h04);
        repeat (4) @(negedge HCLK);
        pad_i = 8'h00;
        tick();
        pop(in_data);
        tick();
        pop(in_data);
        pop(rise_pend);
        push("gl4_back", 8'h00);
        repeat (6) tick();
        pop(in_data);

        @(negedge HCLK);
        irq_clr     = 8'hFF;
        irq_rise_en = 8'h00;
        @(negedge HCLK);
        irq_clr = 8'h00;
        push("gl_clr_irq", 8'h00);
        pop({7'b0, irq});

        // Rising-only capture on pad 1.
        @(negedge HCLK);
        filt_cycles = 4'd0;
        irq_rise_en = 8'h02;
        pad_i       = 8'h02;
        repeat (5) tick();
        @(negedge HCLK);
        pad_i = 8'h00;
        repeat (5) tick();
        push("ir_rise", 8'h02);
        push("ir_fall", 8'h00);
        push("ir_irq", 8'h01);
        pop(rise_pend);
        pop(fall_pend);
        pop({7'b0, irq});

        @(negedge HCLK);
        irq_rise_en = 8'h00;
        tick();
        push("en_keep", 8'h02);
        pop(rise_pend);

        @(negedge HCLK);
        irq_rise_en = 8'h02;
        pad_i       = 8'h02;
        tick();
        tick();
        push("sw_pre_in", 8'h00);
        pop(in_data);
        @(negedge HCLK);
        irq_clr = 8'h02;
        tick();
        push("sw_in", 8'h02);
        push("sw_rise", 8'h02);
        pop(in_data);
        pop(rise_pend);

        @(negedge HCLK);
        irq_clr = 8'h00;
        @(negedge HCLK);
        irq_clr = 8'h02;
        tick();
        push("clr_irq", 8'h00);
        push("clr_rise", 8'h00);
        pop({7'b0, irq});
        pop(rise_pend);

        @(negedge HCLK);
        irq_clr     = 8'h00;
        irq_fall_en = 8'h02;
        pad_i       = 8'h00;
        repeat (5) tick();
        push("fall_pend", 8'h02);
        push("fall_irq", 8'h01);
        pop(fall_pend);
        pop({7'b0, irq});
        @(negedge HCLK);
        irq_clr     = 8'h02;
        irq_fall_en = 8'h00;
        @(negedge HCLK);
        irq_clr = 8'h00;

        // Reset mid-operation with a filter count running on pad 3.
        @(negedge HCLK);
        open_drain  = 8'h00;
        out_en      = 8'hFF;
        out_data    = 8'h55;
        filt_cycles = 4'd10;
        irq_rise_en = 8'hFF;
        pad_i       = 8'h08;
        repeat (4) tick();
        push("mr_pre_noe", 8'h00);
        push("mr_pre_o", 8'h55);
        pop(pad_noe);
        pop(pad_o);
        tick();
        #2;
        HRESETn = 1'b0;
        #1;
        push("mr_noe", 8'hFF);
        push("mr_o", 8'h00);
        pop(pad_noe);
        pop(pad_o);

        @(negedge HCLK);
        filt_cycles = 4'd2;
        repeat (2) tick();
        push("mr_in", 8'h00);
        push("mr_rise", 8'h00);
        push("mr_fall", 8'h00);
        pop(in_data);
        pop(rise_pend);
        pop(fall_pend);

        @(negedge HCLK);
        HRESETn = 1'b1;
        push("mr_hold", 8'h00);
        push("mr_acq", 8'h08);
        push("mr_acq_rise", 8'h08);
        repeat (4) tick();
        pop(in_data);
        tick();
        pop(in_data);
        pop(rise_pend);

        chk("sb_drain", 8'(sb.size()), 8'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, errs);
        $finish;
    end

endmodule
